// File: rtl/permute_arbiter.sv
// Round-robin arbiter sharing one permute engine between NUM_REQ requesters.
// Grants one job at a time, waits for the engine's finish edge or a watchdog timeout.
module permute_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 10,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       err,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic                     perm_start,
    output logic [IDX_W-1:0]         perm_index,
    input  logic                     perm_finish
);

    localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LastId = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {StIdle, StStart, StWait, StDone, StAbort} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic                 finish_q, finish_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d, done_q, done_d, err_q, err_d;
    logic                 start_q, start_d, busy_q, busy_d;

    // Rotate requests so bit k is requester (rr_q + k) mod NUM_REQ.
    logic [2*NUM_REQ-1:0] req_dbl, req_shift;
    logic [NUM_REQ:0]     req_rot;
    logic [ID_W:0]        off, sum;
    logic [ID_W-1:0]      pick;
    logic                 pick_valid;
    logic [IDX_W-1:0]     idx_sel;
    logic [NUM_REQ-1:0]   pick_oh, grant_oh;
    logic                 rise;

    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> rr_q;
    assign req_rot   = req_shift[NUM_REQ:0];

    always_comb begin
        off        = '0;
        pick_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_rot[k]) begin
                off        = (ID_W + 1)'(k);
                pick_valid = 1'b1;
            end
        end
        sum  = {1'b0, rr_q} + off;
        pick = (sum >= (ID_W + 1)'(NUM_REQ)) ? ID_W'(sum - (ID_W + 1)'(NUM_REQ)) : ID_W'(sum);
    end

    assign idx_sel  = IDX_W'(req_index >> (32'(pick) * IDX_W));
    assign pick_oh  = {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick;
    assign grant_oh = {{(NUM_REQ - 1){1'b0}}, 1'b1} << grant_q;
    assign rise     = perm_finish & ~finish_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        index_d  = index_q;
        timer_d  = timer_q;
        finish_d = finish_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = '0;
        start_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StStart;
                    grant_d = pick;
                    index_d = idx_sel;
                    ack_d   = pick_oh;
                    start_d = 1'b1;
                end
            end
            StStart: begin
                state_d  = StWait;
                timer_d  = '0;
                finish_d = perm_finish;
            end
            StWait: begin
                finish_d = perm_finish;
                // A finish edge on the expiry cycle still counts as a normal completion.
                if (rise) begin
                    state_d = StDone;
                    done_d  = grant_oh;
                end else if (TIMEOUT != 0 && timer_q == TimerLast) begin
                    state_d = StAbort;
                    err_d   = grant_oh;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone, StAbort: begin
                state_d = StIdle;
                rr_d    = grant_q;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= LastId;
            rr_q     <= LastId;
            index_q  <= '0;
            timer_q  <= '0;
            finish_q <= 1'b0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            index_q  <= index_d;
            timer_q  <= timer_d;
            finish_q <= finish_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;
    assign perm_start = start_q;
    assign perm_index = index_q;

endmodule

// File: tb/tb_permute_arbiter.sv
// Bench for permute_arbiter: directed scenarios plus random jobs checked against a
// transaction-level model of grant order, index routing and completion latency.
module tb_permute_arbiter;

    localparam int NREQ = 4;
    localparam int IW   = 10;
    localparam int TO   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ*IW-1:0] req_index;
    logic [NREQ-1:0]  ack, done, err;
    logic             busy;
    logic [1:0]       grant_id;
    logic             perm_start;
    logic [IW-1:0]    perm_index;
    logic             perm_finish;

    int n_checks = 0;
    int n_errors = 0;
    int rr_model = NREQ - 1;
    logic [IW-1:0] idx_tab [NREQ];

    permute_arbiter #(
        .NUM_REQ(NREQ),
        .IDX_W  (IW),
        .ID_W   (2),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_index  (req_index),
        .ack        (ack),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .grant_id   (grant_id),
        .perm_start (perm_start),
        .perm_index (perm_index),
        .perm_finish(perm_finish)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_idx();
        for (int i = 0; i < NREQ; i++) req_index[i*IW +: IW] = idx_tab[i];
    endtask

    // Next owner: first active requester after the last owner, wrapping around.
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(rr_model + i) % NREQ]) return (rr_model + i) % NREQ;
        end
        return -1;
    endfunction

    // d: negedges after the START sample at which finish rises (-1 = never).
    task automatic run_job(input logic [NREQ-1:0] r, input int d, input bit prehigh);
        int g, lat, exp_lat;
        bit ok_done, stray;
        logic [NREQ-1:0] oh;
        g       = pick(r);
        oh      = 4'b0001 << g;
        ok_done = (d >= 0 && d <= TO);
        exp_lat = ok_done ? d + 1 : TO + 1;
        lat     = -1;
        stray   = 1'b0;
        req         = r;
        perm_finish = prehigh;
        @(negedge clk);
        check_eq("ack", 32'(ack), 32'(oh));
        check_eq("perm_start", 32'(perm_start), 32'd1);
        check_eq("perm_index", 32'(perm_index), 32'(idx_tab[g]));
        check_eq("grant_id", 32'(grant_id), 32'(g));
        check_eq("busy_start", 32'(busy), 32'd1);
        req[g] = 1'b0;
        for (int c = 1; c <= TO + 8 && lat < 0; c++) begin
            @(negedge clk);
            if ((done | err) != '0) begin
                lat = c;
            end else begin
                if (ack != '0 || perm_start) stray = 1'b1;
                if (prehigh && c == 3) perm_finish = 1'b0;
                if (c == d) perm_finish = 1'b1;
            end
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("done", 32'(done), ok_done ? 32'(oh) : 32'd0);
        check_eq("err", 32'(err), ok_done ? 32'd0 : 32'(oh));
        check_eq("no_stray_pulse", 32'(stray), 32'd0);
        rr_model = g;
        @(negedge clk);
        check_eq("idle_after", 32'({busy, ack, done, err}), 32'd0);
        perm_finish = 1'b0;
    endtask

    task automatic reset_mid_wait();
        int g;
        bit noisy;
        g   = pick(4'b0100);
        req = 4'b0100;
        perm_finish = 1'b0;
        @(negedge clk);
        check_eq("rst_job_ack", 32'(ack), 32'(4'b0001 << g));
        req = '0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_pulses", 32'({perm_start, ack, done, err}), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'(NREQ - 1));
        check_eq("rst_perm_index", 32'(perm_index), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        rr_model = NREQ - 1;
        noisy    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if ((done | err | ack) != '0 || busy) noisy = 1'b1;
        end
        check_eq("post_rst_quiet", 32'(noisy), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] r;
        int d, sel;
        bit ph;
        rst         = 1'b1;
        req         = '0;
        perm_finish = 1'b0;
        for (int i = 0; i < NREQ; i++) idx_tab[i] = IW'(i + 5);
        load_idx();
        #3;
        check_eq("reset_pulses", 32'({perm_start, ack, done, err}), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_grant_id", 32'(grant_id), 32'(NREQ - 1));
        check_eq("reset_perm_index", 32'(perm_index), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All four requesting: order 0,1,2,3,0 with indices 5..8.
        for (int j = 0; j < 5; j++) run_job(4'b1111, 3 + j, 1'b0);
        req = '0;

        idx_tab[2] = 10'd37;
        load_idx();
        run_job(4'b0100, 12, 1'b0);
        run_job(4'b0001, 8, 1'b1);
        run_job(4'b1010, -1, 1'b0);
        run_job(4'b0010, 4, 1'b0);
        run_job(4'b0001, TO, 1'b0);
        reset_mid_wait();
        run_job(4'b1000, 6, 1'b0);

        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < NREQ; i++) idx_tab[i] = IW'($urandom_range(0, 1023));
            load_idx();
            r   = 4'($urandom_range(1, 15));
            sel = $urandom_range(0, 9);
            d   = (sel == 0) ? -1 : ((sel == 1) ? TO : $urandom_range(2, TO - 1));
            ph  = (d >= 6) && ($urandom_range(0, 3) == 0);
            run_job(r, d, ph);
            req = '0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
